// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - op stream and instruction-memory write bus of the program loader
interface prog_loader_if #(
    parameter int AW = 5
);
    logic          op_valid;
    logic [2:0]    op;
    logic [AW-1:0] operand;
    logic          op_last;
    logic          op_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [7:0]    imem_wdata;

    modport master (
        output op_valid, op, operand, op_last,
        input  op_ready, imem_we, imem_addr, imem_wdata
    );
    modport slave (
        input  op_valid, op, operand, op_last,
        output op_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - encodes (op, operand) pairs into imem words and holds the CPU in reset while loading
// Optional FILL_NOP_EN: overwrite unused words after the program with NOP before release.
module prog_loader #(
    parameter int AW        = 5,
    parameter int RUN_DELAY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         cpu_reset,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam logic [AW-1:0] LAST_ADDR = '1;
    localparam int            CW        = $clog2(RUN_DELAY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef FILL_NOP_EN
        S_FILL,
`endif
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] ptr, ptr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ready_q, ready_n;
    logic          we_q, we_n;
    logic [AW-1:0] addr_q, addr_n;
    logic [7:0]    wdata_q, wdata_n;
    logic          cpu_reset_n, busy_n, done_n, err_n;
    logic          xfer, illegal;

    function automatic logic [7:0] encode(input logic [2:0] o, input logic [AW-1:0] v);
        logic [4:0] a;
        a = 5'(v);
        case (o)
            3'd1:    encode = {4'b0001, v[3:0]};
            3'd2:    encode = {4'b0010, v[3:0]};
            3'd3:    encode = {3'b100, a};
            3'd4:    encode = {3'b101, a};
            3'd5:    encode = {3'b110, a};
            3'd6:    encode = {3'b111, a};
            default: encode = 8'h00;
        endcase
    endfunction

    assign xfer    = bus.op_valid & ready_q;
    // Immediates only carry 4 bits; anything above them is a host error
    assign illegal = (bus.op == 3'd7) ||
                     (((bus.op == 3'd1) || (bus.op == 3'd2)) && ((bus.operand >> 4) != '0));

    assign bus.op_ready   = ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            ready_q   <= ready_n;
            we_q      <= we_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            cpu_reset <= cpu_reset_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        cnt_n       = cnt;
        ready_n     = ready_q;
        we_n        = 1'b0;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        cpu_reset_n = cpu_reset;
        busy_n      = busy;
        done_n      = done;
        err_n       = err;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_n     = S_LOAD;
                    ptr_n       = '0;
                    ready_n     = 1'b1;
                    cpu_reset_n = 1'b1;
                    busy_n      = 1'b1;
                    done_n      = 1'b0;
                    err_n       = 1'b0;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    if (illegal) begin
                        state_n = S_ERR;
                        ready_n = 1'b0;
                        err_n   = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        we_n    = 1'b1;
                        addr_n  = ptr;
                        wdata_n = encode(bus.op, bus.operand);
                        // Pointer saturates at the top word; a full memory is an implicit last
                        if (ptr != LAST_ADDR) ptr_n = ptr + 1'b1;
                        if (bus.op_last || (ptr == LAST_ADDR)) begin
                            ready_n = 1'b0;
                            cnt_n   = '0;
`ifdef FILL_NOP_EN
                            state_n = (ptr != LAST_ADDR) ? S_FILL : S_RUN;
`else
                            state_n = S_RUN;
`endif
                        end
                    end
                end
            end
`ifdef FILL_NOP_EN
            S_FILL: begin
                we_n    = 1'b1;
                addr_n  = ptr;
                wdata_n = 8'h00;
                if (ptr == LAST_ADDR) begin
                    state_n = S_RUN;
                    cnt_n   = '0;
                end else begin
                    ptr_n = ptr + 1'b1;
                end
            end
`endif
            S_RUN: begin
                // The final-write cycle plus RUN_DELAY further cycles keep the CPU held
                if (cnt == CW'(RUN_DELAY)) begin
                    state_n     = S_DONE;
                    cpu_reset_n = 1'b0;
                    done_n      = 1'b1;
                    busy_n      = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader against a behavioural model
module tb_prog_loader;
    localparam int AW    = 5;
    localparam int RD    = 2;
    localparam int DEPTH = 1 << AW;
`ifdef FILL_NOP_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif
    localparam int M_IDLE = 0, M_LOAD = 1, M_FILL = 2, M_RUN = 3, M_DONE = 4, M_ERR = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cpu_reset, busy, done, err;

    prog_loader_if #(.AW(AW)) bus ();

    prog_loader #(.AW(AW), .RUN_DELAY(RD)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_reset(cpu_reset),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic       e_ready, e_we, e_cpu_reset, e_busy, e_done, e_err;
    logic [7:0] e_addr, e_wdata;
    int         mode = M_IDLE;
    int         m_ptr = 0;
    int         release_at = 0;
    bit         armed = 1'b0;
    logic [7:0] exp_mem [DEPTH];
    logic [7:0] dut_mem [DEPTH];
    int         wr_count = 0;
    int         last_wr_cyc = 0;
    int         fall_cyc = 0;
    logic       prev_cpu_reset = 1'b1;
    int         p_op [DEPTH];
    int         p_v  [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] enc(input int o, input int v);
        if (o == 0) return 8'h00;
        if (o == 1 || o == 2) return 8'(o * 16 + (v % 16));
        return 8'(128 + (o - 3) * 32 + (v % 32));
    endfunction

    function automatic bit legal(input int o, input int v);
        return (o != 7) && !((o == 1 || o == 2) && v >= 16);
    endfunction

    // Monitor + model: check this cycle's outputs, then predict the next cycle from this cycle's inputs
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i] = 8'h5A;
            dut_mem[i] = 8'h5A;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (armed) begin
                check("op_ready", bus.op_ready, e_ready);
                check("imem_we", bus.imem_we, e_we);
                check("cpu_reset", cpu_reset, e_cpu_reset);
                check("busy", busy, e_busy);
                check("done", done, e_done);
                check("err", err, e_err);
                if (e_we) begin
                    check("imem_addr", bus.imem_addr, e_addr);
                    check("imem_wdata", bus.imem_wdata, e_wdata);
                end
            end
            if (bus.imem_we === 1'b1 && !$isunknown(bus.imem_addr)) begin
                dut_mem[bus.imem_addr] = bus.imem_wdata;
                wr_count++;
                last_wr_cyc = cyc;
            end
            if (prev_cpu_reset === 1'b1 && cpu_reset === 1'b0) fall_cyc = cyc;
            prev_cpu_reset = cpu_reset;

            if (reset) begin
                e_ready = 0; e_we = 0; e_addr = 0; e_wdata = 0;
                e_cpu_reset = 1; e_busy = 0; e_done = 0; e_err = 0;
                mode = M_IDLE; m_ptr = 0; armed = 1'b1;
            end else begin
                e_we = 0;
                case (mode)
                    M_IDLE, M_DONE, M_ERR: if (start) begin
                        mode = M_LOAD; m_ptr = 0;
                        e_ready = 1; e_busy = 1; e_cpu_reset = 1; e_done = 0; e_err = 0;
                    end
                    M_LOAD: if (bus.op_valid && e_ready) begin
                        if (!legal(int'(bus.op), int'(bus.operand))) begin
                            mode = M_ERR; e_ready = 0; e_err = 1; e_busy = 0;
                        end else begin
                            e_we = 1; e_addr = 8'(m_ptr);
                            e_wdata = enc(int'(bus.op), int'(bus.operand));
                            exp_mem[m_ptr] = e_wdata;
                            if (bus.op_last || m_ptr == DEPTH - 1) begin
                                e_ready = 0;
                                if (FILL && m_ptr < DEPTH - 1) mode = M_FILL;
                                else begin
                                    mode = M_RUN;
                                    release_at = cyc + 1 + RD + 1;
                                end
                            end
                            m_ptr++;
                        end
                    end
                    M_FILL: begin
                        e_we = 1; e_addr = 8'(m_ptr); e_wdata = 8'h00;
                        exp_mem[m_ptr] = 8'h00;
                        if (m_ptr == DEPTH - 1) begin
                            mode = M_RUN;
                            release_at = cyc + 1 + RD + 1;
                        end
                        m_ptr++;
                    end
                    M_RUN: if (cyc + 1 == release_at) begin
                        mode = M_DONE; e_cpu_reset = 0; e_done = 1; e_busy = 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int o, input int v, input bit last, input int maxgap);
        bit ok;
        repeat ($urandom_range(0, maxgap)) begin
            bus.op_valid = 1'b0;
            if ($urandom_range(0, 7) == 0) start = 1'b1;
            tick();
            start = 1'b0;
        end
        bus.op_valid = 1'b1;
        bus.op       = 3'(o);
        bus.operand  = AW'(v);
        bus.op_last  = last;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.op_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        bus.op_valid = 1'b0;
        bus.op_last  = 1'b0;
        check("op_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_end();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (done === 1'b1 || err === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        tick();
        check("session_end", 32'(seen), 32'd1);
    endtask

    task automatic rand_op(output int o, output int v);
        o = $urandom_range(0, 6);
        v = (o == 1 || o == 2) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH - 1);
    endtask

    task automatic run_prog(input int n, input bit use_last, input int maxgap);
        wr_count = 0;
        pulse_start();
        for (int i = 0; i < n; i++) send(p_op[i], p_v[i], use_last && (i == n - 1), maxgap);
        wait_end();
    endtask

    task automatic cmp_mem();
        for (int i = 0; i < DEPTH; i++) check($sformatf("imem[%0d]", i), dut_mem[i], exp_mem[i]);
    endtask

    initial begin
        bus.op_valid = 1'b0;
        bus.op       = 3'd0;
        bus.operand  = '0;
        bus.op_last  = 1'b0;

        tick();
        check("rst_op_ready", bus.op_ready, 1'b0);
        check("rst_imem_we", bus.imem_we, 1'b0);
        check("rst_imem_addr", bus.imem_addr, 5'd0);
        check("rst_imem_wdata", bus.imem_wdata, 8'h00);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // Directed program: LOADI 5, ADDI 3, STORE 4, JMP 0
        p_op[0] = 1; p_v[0] = 5;
        p_op[1] = 2; p_v[1] = 3;
        p_op[2] = 5; p_v[2] = 4;
        p_op[3] = 6; p_v[3] = 0;
        run_prog(4, 1'b1, 0);
        check("t1_w0", dut_mem[0], 8'h15);
        check("t1_w1", dut_mem[1], 8'h23);
        check("t1_w2", dut_mem[2], 8'hC4);
        check("t1_w3", dut_mem[3], 8'hE0);
        check("t1_done", done, 1'b1);
        check("t1_cpu_reset", cpu_reset, 1'b0);
        check("t1_release_gap", 32'(fall_cyc - last_wr_cyc), 32'd3);
        check("t1_writes", 32'(wr_count), FILL ? 32'd32 : 32'd4);

        // Two-op program: fill behaviour decides what happens to the stale word at 2
        p_op[0] = 3; p_v[0] = 7;
        p_op[1] = 0; p_v[1] = 0;
        run_prog(2, 1'b1, 0);
        check("t2_w0", dut_mem[0], 8'h87);
        check("t2_w2", dut_mem[2], FILL ? 8'h00 : 8'hC4);
        check("t2_writes", 32'(wr_count), FILL ? 32'd32 : 32'd2);
        cmp_mem();

        // Reserved op at ptr 1
        wr_count = 0;
        pulse_start();
        send(1, 9, 1'b0, 0);
        send(7, 0, 1'b0, 0);
        repeat (3) tick();
        check("t3a_err", err, 1'b1);
        check("t3a_cpu_reset", cpu_reset, 1'b1);
        check("t3a_op_ready", bus.op_ready, 1'b0);
        check("t3a_writes", 32'(wr_count), 32'd1);

        // Immediate with upper operand bits set
        wr_count = 0;
        pulse_start();
        send(2, 'h13, 1'b0, 0);
        repeat (3) tick();
        check("t3b_err", err, 1'b1);
        check("t3b_busy", busy, 1'b0);
        check("t3b_writes", 32'(wr_count), 32'd0);

        // Full memory with no op_last: implicit last at the top address
        for (int i = 0; i < DEPTH; i++) rand_op(p_op[i], p_v[i]);
        run_prog(DEPTH, 1'b0, 2);
        check("t4_writes", 32'(wr_count), 32'd32);
        check("t4_done", done, 1'b1);
        cmp_mem();

        // Random sessions with gaps and ignored start pulses
        for (int s = 0; s < 6; s++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) rand_op(p_op[i], p_v[i]);
            run_prog(n, 1'b1, 3);
            cmp_mem();
        end

        // Reset mid-load at ptr 3, then reload from 0
        pulse_start();
        for (int i = 0; i < 3; i++) send(4, i + 10, 1'b0, 0);
        reset = 1'b1;
        tick();
        check("t6_op_ready", bus.op_ready, 1'b0);
        check("t6_imem_we", bus.imem_we, 1'b0);
        check("t6_imem_addr", bus.imem_addr, 5'd0);
        check("t6_cpu_reset", cpu_reset, 1'b1);
        check("t6_busy", busy, 1'b0);
        reset = 1'b0;
        tick();
        p_op[0] = 1; p_v[0] = 15;
        p_op[1] = 6; p_v[1] = 31;
        run_prog(2, 1'b1, 1);
        check("t6_w0", dut_mem[0], 8'h1F);
        check("t6_w1", dut_mem[1], 8'hFF);
        cmp_mem();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
